// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-channel round-robin byte arbiter.
// Channel indices, FSM states and the pointer-advance helper live here.
package mux4_arb_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } arb_state_t;

  // Index one past the given channel, wrapping at NUM_CH.
  function automatic ch_idx_t nextIdx(input ch_idx_t idx);
    return idx + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational circular priority picker: first set request at or after i_ptr.
// o_any flags that at least one request is present.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  ch_idx_t           i_ptr,
  output ch_idx_t           o_gnt_idx,
  output logic              o_any
);

  ch_idx_t w_idx;
  logic    w_found;

  always_comb begin
    o_gnt_idx = i_ptr;
    w_found   = 1'b0;
    w_idx     = i_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = i_ptr + ch_idx_t'(i);
      if (!w_found && i_req[w_idx]) begin
        o_gnt_idx = w_idx;
        w_found   = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 byte mux between four valid/ready producers,
// with optional per-channel bursts and a single-entry registered output stage.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_CH-1:0]        i_in_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_in_data,
  output logic [NUM_CH-1:0]        o_in_ready,
  output ch_idx_t                  o_sel,
  output logic                     o_out_valid,
  output logic [DATA_W-1:0]        o_out_data,
  output ch_idx_t                  o_out_ch,
  input  logic                     i_out_ready
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_t        r_state;
  arb_state_t        w_stateNext;
  ch_idx_t           r_lastGrant;
  logic [CNT_W-1:0]  r_burstCnt;
  logic              r_granted;
  ch_idx_t           r_sel;
  logic [DATA_W-1:0] r_outData;
  ch_idx_t           r_outCh;

  logic [DATA_W-1:0] w_chData [NUM_CH];
  ch_idx_t           w_pickIdx;
  logic              w_anyReq;
  logic              w_burstHold;
  logic              w_slotFree;
  logic              w_accept;
  ch_idx_t           w_grant;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_unpack
    assign w_chData[n] = i_in_data[n*DATA_W +: DATA_W];
  end

  rr_pick4 u_pick (
    .i_req     (i_in_valid),
    .i_ptr     (nextIdx(r_lastGrant)),
    .o_gnt_idx (w_pickIdx),
    .o_any     (w_anyReq)
  );

  // A burst continues only after a real grant; right after reset the pointer
  // value is a seed for the scan, not a channel that owns a burst.
  assign w_burstHold = r_granted && i_in_valid[r_lastGrant] &&
                       (int'(r_burstCnt) < BURST_LEN - 1);

  assign w_grant    = w_burstHold ? r_lastGrant : w_pickIdx;
  assign w_slotFree = (r_state == S_EMPTY) || i_out_ready;
  assign w_accept   = w_slotFree && w_anyReq && !i_reset;

  assign o_in_ready = w_accept ? (NUM_CH'(1) << w_grant) : '0;
  assign o_sel      = w_accept ? w_grant : r_sel;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_stateNext = S_FULL;
      S_FULL: begin
        if (w_accept)         w_stateNext = S_FULL;
        else if (i_out_ready) w_stateNext = S_EMPTY;
      end
      default: w_stateNext = S_EMPTY;
    endcase
  end

  always_comb begin
    o_out_valid = (r_state == S_FULL);
    o_out_data  = r_outData;
    o_out_ch    = r_outCh;
  end

  // Pointer, burst count and output byte move only on an actual transfer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lastGrant <= ch_idx_t'(NUM_CH - 1);
      r_burstCnt  <= '0;
      r_granted   <= 1'b0;
      r_sel       <= '0;
      r_outData   <= '0;
      r_outCh     <= '0;
    end else if (w_accept) begin
      r_lastGrant <= w_grant;
      r_burstCnt  <= w_burstHold ? (r_burstCnt + CNT_W'(1)) : '0;
      r_granted   <= 1'b1;
      r_sel       <= w_grant;
      r_outData   <= w_chData[w_grant];
      r_outCh     <= w_grant;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter: rotation, single channel,
// backpressure, bursts (second instance with BURST_LEN=2), chase order, async reset.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  inValid;
  logic [31:0] inData;
  logic        outReady;

  logic [3:0]  inReady1, inReady2;
  logic [1:0]  sel1, sel2;
  logic        outValid1, outValid2;
  logic [7:0]  outData1, outData2;
  logic [1:0]  outCh1, outCh2;

  int total = 0;
  int bad   = 0;

  mux4_rr_arbiter #(.DATA_W(8), .BURST_LEN(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_in_valid(inValid), .i_in_data(inData),
    .o_in_ready(inReady1), .o_sel(sel1), .o_out_valid(outValid1),
    .o_out_data(outData1), .o_out_ch(outCh1), .i_out_ready(outReady)
  );

  mux4_rr_arbiter #(.DATA_W(8), .BURST_LEN(2)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_in_valid(inValid), .i_in_data(inData),
    .o_in_ready(inReady2), .o_sel(sel2), .o_out_valid(outValid2),
    .o_out_data(outData2), .o_out_ch(outCh2), .i_out_ready(outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resets both instances and releases on a falling edge with inputs idle.
  task automatic applyStimulus_reset();
    reset    = 1'b1;
    inValid  = 4'h0;
    inData   = 32'h13121110;
    outReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    inValid  = 4'hF;
    inData   = 32'h13121110;
    outReady = 1'b1;
    @(negedge clk);
    #1;
    total++; if (outValid1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid1); end
    total++; if (outData1 !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data got=%h exp=00", outData1); end
    total++; if (outCh1 !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_ch got=%0d exp=0", outCh1); end
    total++; if (sel1 !== 2'd0) begin bad++; $display("[TB] FAIL reset_sel got=%0d exp=0", sel1); end
    total++; if (inReady1 !== 4'b0000) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=0000", inReady1); end
    inValid = 4'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rotation();
    logic [1:0] expCh [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    applyStimulus_reset();
    inValid = 4'hF;
    #1;
    total++; if (inReady1 !== 4'b0001) begin bad++; $display("[TB] FAIL rot_first_ready got=%b exp=0001", inReady1); end
    total++; if (sel1 !== 2'd0) begin bad++; $display("[TB] FAIL rot_first_sel got=%0d exp=0", sel1); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (outValid1 !== 1'b1 || outCh1 !== expCh[k] || outData1 !== 8'h10 + 8'(expCh[k])) begin
        bad++;
        $display("[TB] FAIL rot_step%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                 k, outValid1, outCh1, outData1, expCh[k], 8'h10 + 8'(expCh[k]));
      end
    end
  endtask

  task automatic test_single();
    applyStimulus_reset();
    inData  = 32'h13A51110;
    inValid = 4'b0100;
    #1;
    total++; if (inReady1 !== 4'b0100) begin bad++; $display("[TB] FAIL single_ready got=%b exp=0100", inReady1); end
    total++; if (sel1 !== 2'd2) begin bad++; $display("[TB] FAIL single_sel got=%0d exp=2", sel1); end
    @(negedge clk);
    inValid = 4'b0000;
    total++;
    if (outValid1 !== 1'b1 || outData1 !== 8'hA5 || outCh1 !== 2'd2) begin
      bad++;
      $display("[TB] FAIL single_out got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", outValid1, outData1, outCh1);
    end
    @(negedge clk);
    total++; if (outValid1 !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got=%b exp=0", outValid1); end
  endtask

  task automatic test_backpressure();
    logic [1:0] expCh [3] = '{2'd2, 2'd3, 2'd0};
    applyStimulus_reset();
    inValid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (outValid1 !== 1'b1 || outCh1 !== 2'd1 || outData1 !== 8'h11 || inReady1 !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d got v=%b ch=%0d d=%h rdy=%b exp v=1 ch=1 d=11 rdy=0000",
                 k, outValid1, outCh1, outData1, inReady1);
      end
      @(negedge clk);
    end
    outReady = 1'b1;
    #1;
    total++; if (inReady1 !== 4'b0100) begin bad++; $display("[TB] FAIL bp_release_ready got=%b exp=0100", inReady1); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (outCh1 !== expCh[k] || outData1 !== 8'h10 + 8'(expCh[k])) begin
        bad++;
        $display("[TB] FAIL bp_resume%0d got ch=%0d d=%h exp ch=%0d", k, outCh1, outData1, expCh[k]);
      end
    end
  endtask

  task automatic test_burst();
    logic [1:0] expCh [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    applyStimulus_reset();
    inValid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (outValid2 !== 1'b1 || outCh2 !== expCh[k] || outData2 !== 8'h10 + 8'(expCh[k])) begin
        bad++;
        $display("[TB] FAIL burst_step%0d got v=%b ch=%0d d=%h exp ch=%0d", k, outValid2, outCh2, outData2, expCh[k]);
      end
    end
  endtask

  task automatic test_chase();
    applyStimulus_reset();
    inValid = 4'b0010;
    #1;
    total++; if (inReady1 !== 4'b0010) begin bad++; $display("[TB] FAIL chase_ready0 got=%b exp=0010", inReady1); end
    @(negedge clk);
    total++; if (outCh1 !== 2'd1) begin bad++; $display("[TB] FAIL chase_ch0 got=%0d exp=1", outCh1); end
    inValid = 4'b1010;
    #1;
    total++; if (inReady1 !== 4'b1000) begin bad++; $display("[TB] FAIL chase_ready1 got=%b exp=1000", inReady1); end
    @(negedge clk);
    total++; if (outCh1 !== 2'd3 || outData1 !== 8'h13) begin bad++; $display("[TB] FAIL chase_ch1 got ch=%0d d=%h exp ch=3 d=13", outCh1, outData1); end
    #1;
    total++; if (inReady1 !== 4'b0010) begin bad++; $display("[TB] FAIL chase_ready2 got=%b exp=0010", inReady1); end
    @(negedge clk);
    total++; if (outCh1 !== 2'd1 || outData1 !== 8'h11) begin bad++; $display("[TB] FAIL chase_ch2 got ch=%0d d=%h exp ch=1 d=11", outCh1, outData1); end
  endtask

  task automatic test_async_reset();
    applyStimulus_reset();
    inValid = 4'hF;
    @(negedge clk);
    outReady = 1'b0;
    total++; if (outValid1 !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre got=%b exp=1", outValid1); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (outValid1 !== 1'b0 || outValid2 !== 1'b0) begin bad++; $display("[TB] FAIL areset_immediate got=%b/%b exp=0/0", outValid1, outValid2); end
    total++; if (inReady1 !== 4'b0000) begin bad++; $display("[TB] FAIL areset_ready got=%b exp=0000", inReady1); end
    @(negedge clk);
    reset    = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    total++;
    if (outValid1 !== 1'b1 || outCh1 !== 2'd0 || outData1 !== 8'h10) begin
      bad++;
      $display("[TB] FAIL areset_first got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", outValid1, outCh1, outData1);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_backpressure();
    test_burst();
    test_chase();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
